// File: rtl/onehot_rr_encoder.sv
// onehot_rr_encoder: queues multi-hot request lines as pending bits and emits one
// binary index per VALID/READY transfer, with round-robin or fixed-priority selection.
module onehot_rr_encoder #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  input  logic         ready_i,
  output logic [W-1:0] idx_out_o,
  output logic         valid_o,
  output logic [N-1:0] pend_o,
  output logic         ovr_o
);
  logic [N-1:0] pend_q, pend_d, load_bit;
  logic [W-1:0] idx_q, idx_d, ptr_q, ptr_d, sel, cand;
  logic         valid_q, valid_d, ovr_q, ovr_d, found, slot_free, load;
  // index arithmetic is W bits wide, so ptr+k wraps mod N for free
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = (RR != 0) ? ptr_q + W'(k) : W'(k);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end
  assign slot_free = !valid_q || ready_i;
  assign load      = en_i && slot_free && found;
  assign load_bit  = load ? N'(1) << sel : '0;
  // a request on the line being loaded re-sets its bit, so it is neither lost nor an overrun
  assign pend_d    = en_i ? (pend_q & ~load_bit) | req_i : pend_q;
  assign valid_d   = slot_free ? load : valid_q;
  assign idx_d     = load ? sel : idx_q;
  assign ptr_d     = load ? sel + W'(1) : ptr_q;
  assign ovr_d     = en_i && |(req_i & pend_q & ~load_bit);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign idx_out_o = idx_q;
  assign valid_o   = valid_q;
  assign pend_o    = pend_q;
  assign ovr_o     = ovr_q;
endmodule

// File: tb/tb_onehot_rr_encoder.sv
// tb_onehot_rr_encoder: directed vectors on a round-robin and a fixed-priority instance;
// expected indices are queued at stimulus time and popped by per-instance monitors.
module tb_onehot_rr_encoder;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, ready = 1'b1;
  logic [7:0] req = '0;
  logic [2:0] idx1, idx0;
  logic       valid1, valid0, ovr1, ovr0;
  logic [7:0] pend1, pend0;
  int n_chk = 0, n_fail = 0;
  logic [2:0] q1[$], q0[$];

  onehot_rr_encoder #(.N(8), .W(3), .RR(1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .ready_i(ready),
    .idx_out_o(idx1), .valid_o(valid1), .pend_o(pend1), .ovr_o(ovr1));
  onehot_rr_encoder #(.N(8), .W(3), .RR(0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .ready_i(ready),
    .idx_out_o(idx0), .valid_o(valid0), .pend_o(pend0), .ovr_o(ovr0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [2:0] e);
    q1.push_back(e);
    q0.push_back(e);
  endtask

  task automatic both(input string name, input logic v, input logic [7:0] p, input logic o);
    check({name, " valid_rr"}, 32'(valid1), 32'(v));
    check({name, " valid_fp"}, 32'(valid0), 32'(v));
    check({name, " pend_rr"}, 32'(pend1), 32'(p));
    check({name, " pend_fp"}, 32'(pend0), 32'(p));
    check({name, " ovr_rr"}, 32'(ovr1), 32'(o));
    check({name, " ovr_fp"}, 32'(ovr0), 32'(o));
  endtask

  always @(negedge clk) begin
    if (rst_n && valid1 && ready) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_rr: unexpected transfer idx=%0d, expected none", idx1);
      end else check("mon_rr idx", 32'(idx1), 32'(q1.pop_front()));
    end
    if (rst_n && valid0 && ready) begin
      if (q0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_fp: unexpected transfer idx=%0d, expected none", idx0);
      end else check("mon_fp idx", 32'(idx0), 32'(q0.pop_front()));
    end
  end

  initial begin
    tick();
    tick();
    both("reset", 1'b0, 8'h00, 1'b0);
    check("reset idx", 32'(idx1), 32'd0);
    rst_n = 1'b1;
    // burst from ptr 0: 0..7 on consecutive cycles, ptr wraps back to 0
    req = 8'hFF;
    tick();
    req = 8'h00;
    for (int i = 0; i < 8; i++) push2(3'(i));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("burst valid", 32'(valid1), 32'd1);
      check("burst idx", 32'(idx1), 32'(i));
    end
    tick();
    both("burst end", 1'b0, 8'h00, 1'b0);
    // async reset mid-cycle with VALID=1 and PEND=0x0F
    ready = 1'b0;
    req = 8'h10;
    tick();
    req = 8'h0F;
    tick();
    req = 8'h00;
    both("pre reset", 1'b1, 8'h0F, 1'b0);
    check("pre reset idx", 32'(idx1), 32'd4);
    #1 rst_n = 1'b0;
    #1 both("async reset", 1'b0, 8'h00, 1'b0);
    check("async reset idx", 32'(idx1), 32'd0);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    req = 8'h81;
    push2(3'd0);
    push2(3'd7);
    tick();
    req = 8'h00;
    repeat (3) tick();
    both("post reset", 1'b0, 8'h00, 1'b0);
    // single request: visible one edge after sampling, for exactly one cycle
    req = 8'h04;
    tick();
    req = 8'h00;
    both("single sample", 1'b0, 8'h04, 1'b0);
    push2(3'd2);
    tick();
    both("single load", 1'b1, 8'h00, 1'b0);
    check("single idx", 32'(idx1), 32'd2);
    tick();
    both("single done", 1'b0, 8'h00, 1'b0);
    // backpressure holds index 0 while index 2 waits in PEND
    ready = 1'b0;
    req = 8'h05;
    tick();
    req = 8'h00;
    push2(3'd0);
    push2(3'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      both("bp hold", 1'b1, 8'h04, 1'b0);
      check("bp idx", 32'(idx1), 32'd0);
    end
    ready = 1'b1;
    tick();
    check("bp second idx", 32'(idx1), 32'd2);
    tick();
    both("bp done", 1'b0, 8'h00, 1'b0);
    // fairness: serve 5 then 0x21 gives 0,5 on both instances
    req = 8'h20;
    tick();
    req = 8'h00;
    push2(3'd5);
    repeat (2) tick();
    req = 8'h21;
    tick();
    req = 8'h00;
    push2(3'd0);
    push2(3'd5);
    repeat (3) tick();
    // serve 4 then 0x30: round-robin gives 5,4, fixed priority gives 4,5
    req = 8'h10;
    tick();
    req = 8'h00;
    push2(3'd4);
    repeat (2) tick();
    req = 8'h30;
    tick();
    req = 8'h00;
    q1.push_back(3'd5);
    q1.push_back(3'd4);
    q0.push_back(3'd4);
    q0.push_back(3'd5);
    repeat (3) tick();
    both("fair done", 1'b0, 8'h00, 1'b0);
    // overrun: REQ[3] twice while slot occupied
    ready = 1'b0;
    req = 8'h01;
    tick();
    req = 8'h08;
    tick();
    both("ovr first", 1'b1, 8'h08, 1'b0);
    tick();
    both("ovr pulse", 1'b1, 8'h08, 1'b1);
    req = 8'h00;
    tick();
    both("ovr clear", 1'b1, 8'h08, 1'b0);
    push2(3'd0);
    push2(3'd3);
    ready = 1'b1;
    repeat (3) tick();
    both("ovr done", 1'b0, 8'h00, 1'b0);
    // EN=0: in-flight transfer completes, REQ ignored, PEND holds
    ready = 1'b0;
    req = 8'h02;
    tick();
    req = 8'h04;
    tick();
    req = 8'h00;
    both("en setup", 1'b1, 8'h04, 1'b0);
    push2(3'd1);
    push2(3'd2);
    en = 1'b0;
    req = 8'hFF;
    ready = 1'b1;
    tick();
    both("en0 drain", 1'b0, 8'h04, 1'b0);
    tick();
    both("en0 hold", 1'b0, 8'h04, 1'b0);
    en = 1'b1;
    req = 8'h00;
    tick();
    both("en1 load", 1'b1, 8'h00, 1'b0);
    check("en1 idx", 32'(idx1), 32'd2);
    repeat (2) tick();
    both("final", 1'b0, 8'h00, 1'b0);
    check("queue_rr empty", 32'(q1.size()), 32'd0);
    check("queue_fp empty", 32'(q0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
